// File: rtl/pio_clkdiv_sched.sv
// Per-state-machine fractional clock-enable generator for the PIO block.
// Each SM divides the system clock by INT + FRAC/2^FRAC_W and emits single-cycle tick pulses.
module pio_clkdiv_sched #(
    parameter int NUM_SM = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8,
    localparam int SEL_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic [NUM_SM-1:0] en,
    input  logic [NUM_SM-1:0] restart,
    output logic [NUM_SM-1:0] tick
);

    localparam logic [INT_W:0]   CNT_ONE  = {{INT_W{1'b0}}, 1'b1};
    localparam logic [INT_W:0]   CNT_FULL = {1'b1, {INT_W{1'b0}}};
    localparam logic [INT_W-1:0] INT_ONE  = {{(INT_W-1){1'b0}}, 1'b1};

    // An integer divisor field of zero stands for the full 2^INT_W range.
    function automatic logic [INT_W:0] int_eff(input logic [INT_W-1:0] div_int);
        int_eff = (div_int == {INT_W{1'b0}}) ? CNT_FULL : {1'b0, div_int};
    endfunction

    logic [NUM_SM-1:0] w_pend_vec;

    // Config port accepts unless the target SM still holds an unapplied divisor.
    always_comb begin
        cfg_ready = 1'b1;
        if (int'(cfg_sel) < NUM_SM) begin
            cfg_ready = ~w_pend_vec[cfg_sel];
        end else begin
            cfg_ready = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_SM; g++) begin : g_sm
        logic [INT_W:0]    r_cnt;
        logic [FRAC_W-1:0] r_facc;
        logic [INT_W-1:0]  r_act_int;
        logic [FRAC_W-1:0] r_act_frac;
        logic [INT_W-1:0]  r_pnd_int;
        logic [FRAC_W-1:0] r_pnd_frac;
        logic              r_pend;
        logic              r_tick;

        logic              w_accept;
        logic              w_wrap;
        logic              w_apply;
        logic [INT_W-1:0]  w_div_int;
        logic [FRAC_W-1:0] w_div_frac;
        logic [FRAC_W:0]   w_facc_sum;
        logic [INT_W:0]    w_reload;

        // Wrap/apply decode; a divisor applied on a wrap already governs that reload.
        always_comb begin
            w_accept   = cfg_valid & cfg_ready & (int'(cfg_sel) == g);
            w_wrap     = en[g] & (r_cnt <= CNT_ONE);
            w_apply    = r_pend & (w_wrap | ~en[g] | restart[g]);
            w_div_int  = w_apply ? r_pnd_int  : r_act_int;
            w_div_frac = w_apply ? r_pnd_frac : r_act_frac;
            w_facc_sum = {1'b0, r_facc} + {1'b0, w_div_frac};
            w_reload   = int_eff(w_div_int) + {{INT_W{1'b0}}, w_facc_sum[FRAC_W]};
        end

        // Period counter, fractional accumulator, divisor registers and tick pulse.
        always_ff @(posedge clock) begin
            if (!reset) begin
                r_cnt      <= CNT_ONE;
                r_facc     <= {FRAC_W{1'b0}};
                r_act_int  <= INT_ONE;
                r_act_frac <= {FRAC_W{1'b0}};
                r_pnd_int  <= INT_ONE;
                r_pnd_frac <= {FRAC_W{1'b0}};
                r_pend     <= 1'b0;
                r_tick     <= 1'b0;
            end else begin
                r_tick <= w_wrap & ~restart[g];
                if (restart[g]) begin
                    r_cnt  <= CNT_ONE;
                    r_facc <= {FRAC_W{1'b0}};
                end else if (w_wrap) begin
                    r_cnt  <= w_reload;
                    r_facc <= w_facc_sum[FRAC_W-1:0];
                end else if (en[g]) begin
                    r_cnt  <= r_cnt - CNT_ONE;
                    r_facc <= r_facc;
                end else begin
                    r_cnt  <= r_cnt;
                    r_facc <= r_facc;
                end
                // Accept and apply are exclusive: accept needs pend clear, apply needs it set.
                if (w_apply) begin
                    r_act_int  <= r_pnd_int;
                    r_act_frac <= r_pnd_frac;
                    r_pend     <= 1'b0;
                end else if (w_accept) begin
                    r_pnd_int  <= cfg_int;
                    r_pnd_frac <= cfg_frac;
                    r_pend     <= 1'b1;
                end else begin
                    r_pend     <= r_pend;
                end
            end
        end

        assign w_pend_vec[g] = r_pend;
        assign tick[g]       = r_tick;
    end

endmodule

// File: tb/tb_pio_clkdiv_sched.sv
// Directed bench for pio_clkdiv_sched: vector table plus hand-written multi-cycle sequences.
module tb_pio_clkdiv_sched;

    logic        clock;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_int;
    logic [7:0]  cfg_frac;
    logic [3:0]  en;
    logic [3:0]  restart;
    logic [3:0]  tick;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst;
        logic        v;
        logic [1:0]  sel;
        logic [15:0] ci;
        logic [7:0]  cf;
        logic [3:0]  e;
        logic [3:0]  r;
        logic        rdy;
        logic [3:0]  tk;
    } vec_t;

    vec_t tbl [16];

    pio_clkdiv_sched #(.NUM_SM(4), .INT_W(16), .FRAC_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_sel  (cfg_sel),
        .cfg_int  (cfg_int),
        .cfg_frac (cfg_frac),
        .en       (en),
        .restart  (restart),
        .tick     (tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic v, input logic [1:0] sel,
                                input logic [15:0] ci, input logic [7:0] cf, input logic [3:0] e,
                                input logic [3:0] r, input logic rdy, input logic [3:0] tk);
        vec_t t;
        t.rst = rst; t.v = v; t.sel = sel; t.ci = ci; t.cf = cf;
        t.e = e; t.r = r; t.rdy = rdy; t.tk = tk;
        return t;
    endfunction

    task automatic check_ready(input logic exp, input string name);
        n_tests++;
        if (cfg_ready !== exp) begin
            n_fail++;
            $display("FAIL %s cfg_ready: got %b want %b", name, cfg_ready, exp);
        end
    endtask

    task automatic check_tick(input logic [3:0] exp, input string name);
        n_tests++;
        if (tick !== exp) begin
            n_fail++;
            $display("FAIL %s tick: got %b want %b", name, tick, exp);
        end
    endtask

    // Drive one cycle of inputs, check cfg_ready before the edge and tick after it.
    task automatic cyc(input vec_t v, input string name);
        reset     = v.rst;
        cfg_valid = v.v;
        cfg_sel   = v.sel;
        cfg_int   = v.ci;
        cfg_frac  = v.cf;
        en        = v.e;
        restart   = v.r;
        #1;
        check_ready(v.rdy, name);
        @(posedge clock);
        #1;
        check_tick(v.tk, name);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        cfg_valid = 1'b0;
        cfg_sel   = 2'd0;
        cfg_int   = 16'd0;
        cfg_frac  = 8'd0;
        en        = 4'b0000;
        restart   = 4'b0000;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int gap;
        bit found;

        // SM1 gets 2.5 while idle; SM0 runs at 1.0; then restart and enable-hold on SM1.
        tbl[0]  = mk(1'b1, 1'b1, 2'd1, 16'd2, 8'd128, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        tbl[1]  = mk(1'b1, 1'b0, 2'd1, 16'd2, 8'd128, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        tbl[2]  = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0001, 4'b0000, 1'b1, 4'b0001);
        tbl[3]  = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0011, 4'b0000, 1'b1, 4'b0011);
        tbl[4]  = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0011, 4'b0000, 1'b1, 4'b0001);
        tbl[5]  = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0011, 4'b0000, 1'b1, 4'b0011);
        tbl[6]  = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0011, 4'b0000, 1'b1, 4'b0001);
        tbl[7]  = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0011, 4'b0000, 1'b1, 4'b0001);
        tbl[8]  = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0011, 4'b0000, 1'b1, 4'b0011);
        tbl[9]  = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0011, 4'b0000, 1'b1, 4'b0001);
        tbl[10] = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0011, 4'b0000, 1'b1, 4'b0011);
        tbl[11] = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0011, 4'b0010, 1'b1, 4'b0001);
        tbl[12] = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0011, 4'b0000, 1'b1, 4'b0011);
        tbl[13] = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0001, 4'b0000, 1'b1, 4'b0001);
        tbl[14] = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0011, 4'b0000, 1'b1, 4'b0001);
        tbl[15] = mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0,   4'b0011, 4'b0000, 1'b1, 4'b0011);

        do_reset();
        check_tick(4'b0000, "reset_tick");
        for (int s = 0; s < 4; s++) begin
            cfg_sel = 2'(s);
            #1;
            check_ready(1'b1, $sformatf("reset_ready_sm%0d", s));
        end

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i], $sformatf("tbl%0d", i));
        end

        // Two div-3 SMs out of phase, restarted together on an SM0 wrap cycle.
        do_reset();
        cyc(mk(1'b1, 1'b1, 2'd0, 16'd3, 8'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000), "ph_wr0");
        cyc(mk(1'b1, 1'b1, 2'd1, 16'd3, 8'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000), "ph_wr1");
        cyc(mk(1'b1, 1'b0, 2'd1, 16'd0, 8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000), "ph_apply");
        cyc(mk(1'b1, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0001, 4'b0000, 1'b1, 4'b0001), "ph_sm0");
        cyc(mk(1'b1, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0011, 4'b0000, 1'b1, 4'b0010), "ph_sm1");
        cyc(mk(1'b1, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0011, 4'b0000, 1'b1, 4'b0000), "ph_mid");
        cyc(mk(1'b1, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0011, 4'b0011, 1'b1, 4'b0000), "ph_restart_on_wrap");
        for (int j = 0; j < 9; j++) begin
            cyc(mk(1'b1, 1'b0, 2'd0, 16'd0, 8'd0, 4'b0011, 4'b0000, 1'b1,
                   (j % 3 == 0) ? 4'b0011 : 4'b0000), $sformatf("ph_aligned%0d", j));
        end

        // SM3 at div 4, rewritten to 2 mid-period; second write stalls while pending.
        do_reset();
        cyc(mk(1'b1, 1'b1, 2'd3, 16'd4, 8'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000), "pd_wr4");
        cyc(mk(1'b1, 1'b0, 2'd3, 16'd0, 8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000), "pd_apply4");
        cyc(mk(1'b1, 1'b0, 2'd3, 16'd0, 8'd0, 4'b1000, 4'b0000, 1'b1, 4'b1000), "pd_c0");
        cyc(mk(1'b1, 1'b1, 2'd3, 16'd2, 8'd0, 4'b1000, 4'b0000, 1'b1, 4'b0000), "pd_c1_wr2");
        cyc(mk(1'b1, 1'b1, 2'd3, 16'd2, 8'd0, 4'b1000, 4'b0000, 1'b0, 4'b0000), "pd_c2_stall");
        cyc(mk(1'b1, 1'b1, 2'd3, 16'd2, 8'd0, 4'b1000, 4'b0000, 1'b0, 4'b0000), "pd_c3_stall");
        cyc(mk(1'b1, 1'b1, 2'd3, 16'd2, 8'd0, 4'b1000, 4'b0000, 1'b0, 4'b1000), "pd_c4_wrap");
        cyc(mk(1'b1, 1'b1, 2'd3, 16'd2, 8'd0, 4'b1000, 4'b0000, 1'b1, 4'b0000), "pd_c5_accept");
        cyc(mk(1'b1, 1'b0, 2'd3, 16'd0, 8'd0, 4'b1000, 4'b0000, 1'b0, 4'b1000), "pd_c6");
        cyc(mk(1'b1, 1'b0, 2'd3, 16'd0, 8'd0, 4'b1000, 4'b0000, 1'b1, 4'b0000), "pd_c7");
        cyc(mk(1'b1, 1'b0, 2'd3, 16'd0, 8'd0, 4'b1000, 4'b0000, 1'b1, 4'b1000), "pd_c8");
        cyc(mk(1'b1, 1'b0, 2'd3, 16'd0, 8'd0, 4'b1000, 4'b0000, 1'b1, 4'b0000), "pd_c9");

        // SM2 at div 5: seven disabled cycles stretch one gap to 12, then a mid-run reset.
        do_reset();
        cyc(mk(1'b1, 1'b1, 2'd2, 16'd5, 8'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000), "en_wr5");
        cyc(mk(1'b1, 1'b0, 2'd2, 16'd0, 8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000), "en_apply5");
        for (int j = 0; j <= 12; j++) begin
            cyc(mk(1'b1, (j == 12), 2'd2, 16'd9, 8'd0,
                   (j >= 3 && j <= 9) ? 4'b0000 : 4'b0100, 4'b0000, 1'b1,
                   (j == 0 || j == 12) ? 4'b0100 : 4'b0000), $sformatf("en_hold%0d", j));
        end
        cyc(mk(1'b0, 1'b0, 2'd2, 16'd0, 8'd0, 4'b0100, 4'b0000, 1'b0, 4'b0000), "rst_mid");
        cyc(mk(1'b1, 1'b0, 2'd2, 16'd0, 8'd0, 4'b0100, 4'b0000, 1'b1, 4'b0100), "rst_after0");
        cyc(mk(1'b1, 1'b0, 2'd2, 16'd0, 8'd0, 4'b0100, 4'b0000, 1'b1, 4'b0100), "rst_after1");
        cyc(mk(1'b1, 1'b0, 2'd2, 16'd0, 8'd0, 4'b0100, 4'b0000, 1'b1, 4'b0100), "rst_after2");

        // INT=0 encodes the full 2^16 period.
        do_reset();
        cyc(mk(1'b1, 1'b1, 2'd2, 16'd0, 8'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000), "max_wr");
        cyc(mk(1'b1, 1'b0, 2'd2, 16'd0, 8'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000), "max_apply");
        cyc(mk(1'b1, 1'b0, 2'd2, 16'd0, 8'd0, 4'b0100, 4'b0000, 1'b1, 4'b0100), "max_first");
        gap   = 0;
        found = 1'b0;
        for (int n = 1; n <= 70000 && !found; n++) begin
            @(posedge clock);
            #1;
            if (tick[2]) begin
                found = 1'b1;
                gap   = n;
            end
        end
        n_tests++;
        if (!found || gap != 65536) begin
            n_fail++;
            $display("FAIL max_gap: got %0d (found=%0d) want 65536", gap, found);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
